// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter slice: byte width,
//   arbiter FSM state encoding and a sizing helper for the tx_busy wait counter.
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    // 2-bit arbiter state. IDLE must stay the reset/zero encoding.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Width of a counter that must reach (timeout - 1); never narrower than 1 bit.
    function automatic int wait_cnt_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester byte handshake and the uart_tx pin-level interface
//   seen by the arbiter.
//   Signals:
//     req_valid [N_REQ]      requester i has a byte pending
//     req_data  [N_REQ*8]    requester i byte at [8i+7:8i]
//     req_ready [N_REQ]      one-hot accept strobe from the arbiter
//     tx_start               one-cycle start pulse to uart_tx
//     tx_data   [8]          byte presented to uart_tx
//     tx_busy                uart_tx frame in progress
//   Modports:
//     master  - the arbiter (drives ready and the uart_tx inputs)
//     slave   - requesters plus uart_tx (drive valid/data and busy)
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    import uart_tx_arbiter_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [BYTE_W-1:0]       tx_data;
    logic                    tx_busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  tx_busy,
        output req_ready,
        output tx_start,
        output tx_data
    );

    modport slave (
        output req_valid,
        output req_data,
        output tx_busy,
        input  req_ready,
        input  tx_start,
        input  tx_data
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick
//   Combinational round-robin picker. Searches the valid vector starting one
//   position after ptr (wrapping) and returns the first valid requester.
//   Ports:
//     valid     in  [N_REQ]  request vector
//     ptr       in  [ID_W]   index of the most recently served requester
//     grant_oh  out [N_REQ]  one-hot winner (all zero when nothing is valid)
//     grant_idx out [ID_W]   binary winner index (0 when nothing is valid)
//     any_valid out          at least one request is present
// -----------------------------------------------------------------------------
module uart_tx_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    logic [ID_W-1:0] cand_idx;

    // Offsets 1..N_REQ from ptr visit every requester once, the last served
    // one last, which is what makes a re-asserting winner wait its turn.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!any_valid && valid[cand_idx]) begin
                any_valid          = 1'b1;
                grant_oh[cand_idx] = 1'b1;
                grant_idx          = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx among N_REQ byte requesters with round-robin
//   arbitration. One byte is accepted per valid/ready handshake, presented on
//   tx_data with a one-cycle tx_start, and the transmitter is then tracked via
//   tx_busy until the frame completes.
//   Ports:
//     clk          in            system clock, rising edge
//     rst          in            asynchronous reset, active low
//     bus          master        requester handshake + uart_tx pins
//     grant_id     out [ID_W]    index of the last accepted requester
//     arb_busy     out           high whenever the FSM is not idle
//     timeout_err  out           one-cycle pulse: tx_busy never rose after start
//     tx_count     out [COUNT_W] completed frames, wraps silently
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 64,
    parameter int COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus,
    output logic [ID_W-1:0]    grant_id,
    output logic               arb_busy,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] tx_count
);

    localparam int                WAIT_W    = wait_cnt_w(BUSY_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_TIMEOUT - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;

    logic [N_REQ-1:0]  pick_oh;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [ID_W-1:0]   rr_ptr;

    logic [BYTE_W-1:0] sel_byte;
    logic [BYTE_W-1:0] data_r;
    logic [WAIT_W-1:0] wait_cnt;

    logic [N_REQ-1:0]  req_ready_c;
    logic              tx_start_c;
    logic              handshake;
    logic              timeout_hit;
    logic              frame_done;

    uart_tx_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // Byte of the current winner; constant slice indices keep this a plain mux.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_byte = bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign handshake   = |(bus.req_valid & req_ready_c);
    assign timeout_hit = (state == ST_WAIT_BUSY) && !bus.tx_busy && (wait_cnt == WAIT_LAST);
    assign frame_done  = (state == ST_WAIT_DONE) && !bus.tx_busy;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic. req_ready is gated by rst directly because the state
    // register already reads IDLE while reset is held, which would otherwise
    // let a grant through during reset.
    always_comb begin
        req_ready_c = '0;
        tx_start_c  = 1'b0;
        arb_busy    = 1'b1;
        case (state)
            ST_IDLE: begin
                arb_busy = 1'b0;
                if (rst && !bus.tx_busy) begin
                    req_ready_c = pick_oh;
                end
            end
            ST_START: begin
                tx_start_c = 1'b1;
            end
            default: begin
                tx_start_c = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_start  = tx_start_c;
    assign bus.tx_data   = data_r;

    // Datapath: accepted byte, grant bookkeeping, wait and frame counters.
    // tx_data only loads on a handshake, so it stays stable for the whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r      <= '0;
            grant_id    <= '0;
            rr_ptr      <= ID_W'(N_REQ - 1);
            wait_cnt    <= '0;
            tx_count    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;

            if (handshake) begin
                data_r   <= sel_byte;
                grant_id <= pick_idx;
                rr_ptr   <= pick_idx;
            end

            // Cleared in START so WAIT_BUSY begins counting from zero.
            if (state == ST_START) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT_BUSY) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (frame_done) begin
                tx_count <= tx_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (N_REQ=4, BUSY_TIMEOUT=16,
//   COUNT_W=4) with a behavioural uart_tx that raises tx_busy three cycles
//   after tx_start and holds it for FRAME_LEN cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int N_REQ        = 4;
    localparam int ID_W         = 2;
    localparam int BUSY_TIMEOUT = 16;
    localparam int COUNT_W      = 4;
    localparam int BUSY_DLY     = 3;
    localparam int FRAME_LEN    = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ID_W-1:0]    grant_id;
    logic               arb_busy;
    logic               timeout_err;
    logic [COUNT_W-1:0] tx_count;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ        (N_REQ),
        .ID_W         (ID_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .COUNT_W      (COUNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err),
        .tx_count    (tx_count)
    );

    always #5 clk = ~clk;

    // Requester-side drive
    logic [N_REQ-1:0]        drv_valid = '0;
    logic [N_REQ*BYTE_W-1:0] drv_data  = '0;
    assign bus.req_valid = drv_valid;
    assign bus.req_data  = drv_data;

    // Behavioural uart_tx
    bit   never_busy = 1'b0;
    logic model_busy = 1'b0;
    int   age        = -1;
    logic busy_nxt;
    assign bus.tx_busy = model_busy;

    always begin
        @(negedge clk);
        if (bus.tx_start && !never_busy) age = 0;
        else if (age >= 0) age++;
        if (age >= BUSY_DLY + FRAME_LEN) age = -1;
        busy_nxt = (age >= BUSY_DLY);
        @(posedge clk);
        #1;
        model_busy = busy_nxt;
    end

    // Event counters
    int start_cnt = 0, to_cnt = 0, busy_run = 0, last_run = 0;
    always @(negedge clk) begin
        if (bus.tx_start) start_cnt <= start_cnt + 1;
        if (timeout_err)  to_cnt    <= to_cnt + 1;
        if (arb_busy) busy_run <= busy_run + 1;
        else if (busy_run > 0) begin
            last_run <= busy_run;
            busy_run <= 0;
        end
    end

    // Reference model state
    logic [7:0] q [N_REQ][$];
    int         grant_log [$];
    int         m_ptr      = N_REQ - 1;
    int         exp_frames = 0;
    int         accepted   = 0;
    logic [7:0] last_data  = 8'h00;
    int         last_id    = 0;
    bit         start_exp  = 1'b0;
    bit         rand_drop  = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round robin: the valid requester closest after ptr (cyclic distance).
    function automatic int model_pick(input logic [N_REQ-1:0] v, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                d = (((i - ptr - 1) % N_REQ) + N_REQ) % N_REQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            drv_valid[i] = (q[i].size() > 0) && (!rand_drop || ($urandom_range(0, 3) != 0));
            drv_data[i*BYTE_W +: BYTE_W] = (q[i].size() > 0) ? q[i][0] : 8'h00;
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
    task automatic step();
        int w;
        logic [N_REQ-1:0] er;
        bit acc;
        drive();
        @(negedge clk);
        acc = 1'b0;
        er  = '0;
        w   = model_pick(drv_valid, m_ptr);
        chk("start_pulse", bus.tx_start, start_exp);
        if (bus.tx_start) begin
            chk("start_data", bus.tx_data, last_data);
            chk("start_id", grant_id, last_id);
        end
        if (!arb_busy && !bus.tx_busy) begin
            if (w >= 0) er[w] = 1'b1;
            chk("rr_grant", bus.req_ready, er);
        end else begin
            chk("ready_held", bus.req_ready, 0);
        end
        if ((bus.req_ready & drv_valid) != 0 && w >= 0 && bus.req_ready[w]) begin
            acc       = 1'b1;
            last_data = q[w].pop_front();
            last_id   = w;
            m_ptr     = w;
            accepted++;
            grant_log.push_back(w);
            if (!never_busy) exp_frames++;
        end
        start_exp = acc;
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N_REQ; i++) if (q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic serve(input int budget);
        int n;
        n = 0;
        while ((pending() || arb_busy || bus.tx_busy) && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL serve_bound: observed %0d cycles required below %0d", n, budget);
        end
        chk("tx_count", tx_count, exp_frames % (1 << COUNT_W));
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!bus.tx_busy && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL busy_bound: observed %0d cycles required below %0d", n, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        m_ptr      = N_REQ - 1;
        exp_frames = 0;
        start_exp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, a0;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        #1;
        // Reset with every requester valid and uart idle: ready must stay low.
        drv_valid = '1;
        do_reset();
        drv_valid = '0;

        // Single request from requester 0
        grant_log.delete();
        q[0].push_back(8'hAA);
        serve(200);
        chk("t1_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("t1_winner", grant_log[0], 0);

        // All four requesters, requester 0 has a second byte
        do_reset();
        grant_log.delete();
        q[0].push_back(8'h10); q[0].push_back(8'h10);
        q[1].push_back(8'h11);
        q[2].push_back(8'h12);
        q[3].push_back(8'h13);
        serve(400);
        chk("t2_grants", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("t2_order", grant_log[k], exp_order[k]);
        end
        chk("t2_tx_count", tx_count, 5);

        // tx_busy never rises: one timeout, then normal service resumes
        never_busy = 1'b1;
        t0 = to_cnt;
        q[1].push_back(8'h55);
        serve(300);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("t3_timeouts", to_cnt - t0, 1);
        checks++;
        assert (last_run >= BUSY_TIMEOUT && last_run <= BUSY_TIMEOUT + 2) else begin
            errors++;
            $error("FAIL t3_wait_len: observed %0d cycles required %0d..%0d",
                   last_run, BUSY_TIMEOUT, BUSY_TIMEOUT + 2);
        end
        never_busy = 1'b0;
        grant_log.delete();
        q[2].push_back(8'h66);
        serve(200);
        chk("t3_next_served", grant_log.size(), 1);

        // Reset asserted during WAIT_DONE, all requesters waiting
        q[3].push_back(8'h77);
        wait_busy(100);
        step();
        step();
        for (int i = 0; i < N_REQ; i++) q[i].push_back(8'hC0 + 8'(i));
        drive();
        do_reset();
        grant_log.delete();
        serve(400);
        chk("t4_grants", grant_log.size(), 4);
        if (grant_log.size() > 0) chk("t4_first", grant_log[0], 0);

        // Late requesters arriving mid-frame after requester 2
        grant_log.delete();
        q[2].push_back(8'h22);
        wait_busy(100);
        q[0].push_back(8'h20);
        q[1].push_back(8'h21);
        serve(400);
        chk("t5_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("t5_first", grant_log[0], 2);
            chk("t5_second", grant_log[1], 0);
            chk("t5_third", grant_log[2], 1);
        end

        // 17 random frames with random valid drops: counter wraps to 1
        do_reset();
        rand_drop = 1'b1;
        s0 = start_cnt;
        a0 = accepted;
        for (int n = 0; n < 17; n++) begin
            q[$urandom_range(0, N_REQ - 1)].push_back(8'($urandom));
        end
        serve(3000);
        @(negedge clk);
        @(posedge clk);
        #1;
        rand_drop = 1'b0;
        chk("t6_wrap", tx_count, 1);
        chk("t6_accepted", accepted - a0, 17);
        chk("t6_starts", start_cnt - s0, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
